// File: rtl/edl_pkg.sv
// Shared state encoding and arithmetic helpers for the EDL delay tuner.
package edl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COUNT  = 3'd1,
    S_DECIDE = 3'd2,
    S_REQ_HI = 3'd3,
    S_REQ_LO = 3'd4
  } edl_state_t;

  // Fixed 32-bit operand so callers with any stage count can share it.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

endpackage

// File: rtl/edl_sync2.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
module edl_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/edl_delay_tuner.sv
// Closed-loop delay-code tuner: counts stage errors per window, steps the shared
// delay code up or down, and pushes each new code over a 4-phase handshake.
module edl_delay_tuner
  import edl_pkg::*;
#(
  parameter int N_STAGES  = 4,
  parameter int CODE_W    = 4,
  parameter int INIT_CODE = 8,
  parameter int CODE_MIN  = 1,
  parameter int CODE_MAX  = 15,
  parameter int WINDOW    = 1024,
  parameter int ERRCNT_W  = 8,
  parameter int HI_THR    = 4,
  parameter int LO_THR    = 0,
  parameter int QUIET_WIN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_STAGES-1:0] err,
  input  logic                cfg_ack,
  output logic [CODE_W-1:0]   dly_code,
  output logic                cfg_req,
  output logic                busy,
  output logic [ERRCNT_W-1:0] win_err_cnt,
  output logic                sat_alarm,
  output edl_state_t          dbg_state
);

  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int Q_W   = $clog2(QUIET_WIN + 1);

  localparam logic [WIN_W-1:0]    WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [Q_W-1:0]      Q_LAST   = Q_W'(QUIET_WIN - 1);
  localparam logic [Q_W-1:0]      Q_SAT    = Q_W'(QUIET_WIN);
  localparam logic [ERRCNT_W-1:0] HI_T     = ERRCNT_W'(HI_THR);
  localparam logic [ERRCNT_W-1:0] LO_T     = ERRCNT_W'(LO_THR);
  localparam logic [CODE_W-1:0]   C_MIN    = CODE_W'(CODE_MIN);
  localparam logic [CODE_W-1:0]   C_MAX    = CODE_W'(CODE_MAX);
  localparam logic [CODE_W-1:0]   C_INIT   = CODE_W'(INIT_CODE);
  localparam logic [31:0]         ERR_MAX  = 32'((64'd1 << ERRCNT_W) - 64'd1);

  edl_state_t          state;
  logic [WIN_W-1:0]    win_cnt;
  logic [ERRCNT_W-1:0] err_cnt;
  logic [Q_W-1:0]      quiet_cnt;
  logic                ack_s;
  logic [31:0]         err_ext;
  logic [31:0]         err_sum;
  logic [ERRCNT_W-1:0] err_next;
  logic                unused_err_hi;

  edl_sync2 u_ack_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (cfg_ack),
    .q     (ack_s)
  );

  always_comb begin
    err_ext                 = '0;
    err_ext[N_STAGES-1:0]   = err;
    err_sum = sat_add(32'(err_cnt), 32'(popcount(err_ext)), ERR_MAX);
  end

  assign err_next      = err_sum[ERRCNT_W-1:0];
  assign unused_err_hi = ^err_sum[31:ERRCNT_W];
  assign busy          = (state == S_DECIDE) || (state == S_REQ_HI) || (state == S_REQ_LO);
  assign dbg_state     = state;

  // Handshake: the tuner raises cfg_req with dly_code already stable, holds both
  // until the synchronized ack rises, drops cfg_req, then waits for ack to fall
  // before any new code may be chosen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      win_cnt     <= '0;
      err_cnt     <= '0;
      quiet_cnt   <= '0;
      dly_code    <= C_INIT;
      cfg_req     <= 1'b0;
      win_err_cnt <= '0;
      sat_alarm   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          win_cnt   <= '0;
          err_cnt   <= '0;
          quiet_cnt <= '0;
          if (en) state <= S_COUNT;
        end
        S_COUNT: begin
          if (!en) begin
            win_cnt <= '0;
            err_cnt <= '0;
            state   <= S_IDLE;
          end else if (win_cnt == WIN_LAST) begin
            win_err_cnt <= err_next;
            win_cnt     <= '0;
            err_cnt     <= '0;
            state       <= S_DECIDE;
          end else begin
            win_cnt <= win_cnt + 1'b1;
            err_cnt <= err_next;
          end
        end
        S_DECIDE: begin
          if (win_err_cnt >= HI_T) begin
            quiet_cnt <= '0;
            if (dly_code < C_MAX) begin
              dly_code <= dly_code + 1'b1;
              cfg_req  <= 1'b1;
              state    <= S_REQ_HI;
            end else begin
              sat_alarm <= 1'b1;
              state     <= S_COUNT;
            end
          end else if (win_err_cnt <= LO_T) begin
            if (quiet_cnt >= Q_LAST && dly_code > C_MIN) begin
              dly_code  <= dly_code - 1'b1;
              quiet_cnt <= '0;
              cfg_req   <= 1'b1;
              state     <= S_REQ_HI;
            end else begin
              // Hold at QUIET_WIN once reached so the counter never wraps.
              quiet_cnt <= (quiet_cnt >= Q_LAST) ? Q_SAT : quiet_cnt + 1'b1;
              state     <= S_COUNT;
            end
          end else begin
            quiet_cnt <= '0;
            state     <= S_COUNT;
          end
        end
        S_REQ_HI: begin
          if (ack_s) begin
            cfg_req <= 1'b0;
            state   <= S_REQ_LO;
          end
        end
        S_REQ_LO: begin
          if (!ack_s) state <= en ? S_COUNT : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edl_delay_tuner.sv
// Directed, table-driven bench for edl_delay_tuner with hand-computed expectations.
module tb_edl_delay_tuner;
  import edl_pkg::*;

  localparam int WIN = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] err = '0;
  logic       cfg_ack = 1'b0;
  logic [3:0] dly_code;
  logic       cfg_req;
  logic       busy;
  logic [7:0] win_err_cnt;
  logic       sat_alarm;
  edl_state_t dbg_state;

  logic       en2 = 1'b0;
  logic [3:0] err2 = '0;
  logic       ack2 = 1'b0;
  logic [3:0] dly_code2;
  logic       cfg_req2;
  logic       busy2;
  logic [7:0] win_err_cnt2;
  logic       sat_alarm2;
  edl_state_t dbg_state2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    int         mode;      // 0: n pulses spread from cycle 0, 1: 4'b1111 on last cycle
    int         n;
    logic [7:0] exp_cnt;
    logic       exp_req;
    logic [3:0] exp_code;
  } vec_t;

  vec_t vecs[10];

  edl_delay_tuner #(
    .N_STAGES(4), .CODE_W(4), .INIT_CODE(8), .CODE_MIN(1), .CODE_MAX(15),
    .WINDOW(WIN), .ERRCNT_W(8), .HI_THR(4), .LO_THR(0), .QUIET_WIN(2)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .err(err), .cfg_ack(cfg_ack),
    .dly_code(dly_code), .cfg_req(cfg_req), .busy(busy),
    .win_err_cnt(win_err_cnt), .sat_alarm(sat_alarm), .dbg_state(dbg_state)
  );

  // Long window so one window can carry 300 pulses.
  edl_delay_tuner #(
    .N_STAGES(4), .CODE_W(4), .INIT_CODE(8), .CODE_MIN(1), .CODE_MAX(15),
    .WINDOW(128), .ERRCNT_W(8), .HI_THR(4), .LO_THR(0), .QUIET_WIN(2)
  ) u_sat (
    .clk(clk), .rst(rst), .en(en2), .err(err2), .cfg_ack(ack2),
    .dly_code(dly_code2), .cfg_req(cfg_req2), .busy(busy2),
    .win_err_cnt(win_err_cnt2), .sat_alarm(sat_alarm2), .dbg_state(dbg_state2)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Driver and checker tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] gen_err(input int mode, input int n, input int c);
    logic [3:0] one;
    one = 4'b0001;
    if (mode == 1) return (c == WIN - 1) ? 4'hF : 4'h0;
    return (c < n) ? (one << (c % 4)) : 4'h0;
  endfunction

  // Called with the DUT in COUNT at window cycle 0; returns one cycle after DECIDE.
  task automatic feed_window(input int mode, input int n);
    for (int c = 0; c < WIN; c++) begin
      err = gen_err(mode, n, c);
      tick();
    end
    err = '0;
    check("state_decide", 32'(dbg_state), 32'(S_DECIDE));
    tick();
  endtask

  task automatic handshake(input edl_state_t exp_after);
    int k;
    logic [3:0] held;
    held = dly_code;
    cfg_ack = 1'b1;
    k = 0;
    while (cfg_req && k < 10) begin
      tick();
      k++;
    end
    check("req_fall", 32'(cfg_req), 32'd0);
    check("code_held", 32'(dly_code), 32'(held));
    cfg_ack = 1'b0;
    k = 0;
    while (dbg_state == S_REQ_LO && k < 10) begin
      tick();
      k++;
    end
    check("state_after_hs", 32'(dbg_state), 32'(exp_after));
  endtask

  initial begin
    vecs[0] = '{0, 5, 8'd5, 1'b1, 4'd9};
    vecs[1] = '{1, 0, 8'd4, 1'b1, 4'd10};
    vecs[2] = '{0, 0, 8'd0, 1'b0, 4'd10};
    vecs[3] = '{0, 1, 8'd1, 1'b0, 4'd10};
    vecs[4] = '{0, 0, 8'd0, 1'b0, 4'd10};
    vecs[5] = '{0, 0, 8'd0, 1'b1, 4'd9};
    vecs[6] = '{0, 3, 8'd3, 1'b0, 4'd9};
    vecs[7] = '{0, 4, 8'd4, 1'b1, 4'd10};
    vecs[8] = '{0, 0, 8'd0, 1'b0, 4'd10};
    vecs[9] = '{0, 0, 8'd0, 1'b1, 4'd9};
    foreach (vecs[i]) exp_q.push_back(vecs[i].exp_cnt);

    #2 rst = 1'b0;
    repeat (2) tick();
    check("rst_code", 32'(dly_code), 32'd8);
    check("rst_req", 32'(cfg_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(win_err_cnt), 32'd0);
    check("rst_alarm", 32'(sat_alarm), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b1;
    tick();
    en = 1'b1;
    tick();
    check("enter_count", 32'(dbg_state), 32'(S_COUNT));

    // Table: each row is one window followed by its decision.
    for (int i = 0; i < 10; i++) begin
      logic [7:0] exp_cnt;
      exp_cnt = exp_q.pop_front();
      feed_window(vecs[i].mode, vecs[i].n);
      check("win_err_cnt", 32'(win_err_cnt), 32'(exp_cnt));
      check("cfg_req", 32'(cfg_req), 32'(vecs[i].exp_req));
      check("dly_code", 32'(dly_code), 32'(vecs[i].exp_code));
      check("busy", 32'(busy), 32'(vecs[i].exp_req));
      if (cfg_req) handshake(S_COUNT);
    end

    // Climb to CODE_MAX, then one more hot window must only raise the alarm.
    for (int k = 10; k <= 15; k++) begin
      feed_window(0, 6);
      check("climb_req", 32'(cfg_req), 32'd1);
      check("climb_code", 32'(dly_code), 32'(k));
      if (cfg_req) handshake(S_COUNT);
    end
    check("alarm_before_max", 32'(sat_alarm), 32'd0);
    feed_window(0, 6);
    check("max_cnt", 32'(win_err_cnt), 32'd6);
    check("max_code", 32'(dly_code), 32'd15);
    check("max_no_req", 32'(cfg_req), 32'd0);
    check("max_alarm", 32'(sat_alarm), 32'd1);
    check("max_state", 32'(dbg_state), 32'(S_COUNT));
    if (cfg_req) handshake(S_COUNT);

    // Partial window dropped by en=0 must not leak into the next window.
    err = 4'hF;
    repeat (8) tick();
    err = '0;
    en = 1'b0;
    tick();
    check("partial_idle", 32'(dbg_state), 32'(S_IDLE));
    en = 1'b1;
    tick();
    check("partial_count", 32'(dbg_state), 32'(S_COUNT));
    feed_window(0, 0);
    check("partial_cnt", 32'(win_err_cnt), 32'd0);
    check("partial_req", 32'(cfg_req), 32'd0);
    check("alarm_sticky", 32'(sat_alarm), 32'd1);

    // Reset in the middle of a request.
    feed_window(0, 0);
    check("pre_rst_req", 32'(cfg_req), 32'd1);
    check("pre_rst_code", 32'(dly_code), 32'd14);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_req", 32'(cfg_req), 32'd0);
    check("mid_rst_code", 32'(dly_code), 32'd8);
    check("mid_rst_alarm", 32'(sat_alarm), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_count", 32'(dbg_state), 32'(S_COUNT));

    // Walk down to CODE_MIN: each step needs two quiet windows.
    for (int k = 7; k >= 1; k--) begin
      feed_window(0, 0);
      check("down_first_req", 32'(cfg_req), 32'd0);
      check("down_first_code", 32'(dly_code), 32'(k + 1));
      if (cfg_req) handshake(S_COUNT);
      feed_window(0, 0);
      check("down_req", 32'(cfg_req), 32'd1);
      check("down_code", 32'(dly_code), 32'(k));
      if (cfg_req) handshake(S_COUNT);
    end
    for (int r = 0; r < 3; r++) begin
      feed_window(0, 0);
      check("min_no_req", 32'(cfg_req), 32'd0);
      check("min_code", 32'(dly_code), 32'd1);
      if (cfg_req) handshake(S_COUNT);
    end

    // en dropped during REQ_HI: handshake still completes, then IDLE.
    feed_window(0, 6);
    check("en_off_req", 32'(cfg_req), 32'd1);
    check("en_off_code", 32'(dly_code), 32'd2);
    en = 1'b0;
    if (cfg_req) handshake(S_IDLE);
    check("en_off_busy", 32'(busy), 32'd0);
    tick();
    check("en_off_stay_idle", 32'(dbg_state), 32'(S_IDLE));

    // Saturating error counter: 300 pulses in one 128-cycle window.
    en2 = 1'b1;
    tick();
    check("sat_count", 32'(dbg_state2), 32'(S_COUNT));
    err2 = 4'hF;
    repeat (75) tick();
    err2 = '0;
    begin
      int k;
      k = 0;
      while (dbg_state2 != S_DECIDE && k < 200) begin
        tick();
        k++;
      end
    end
    check("sat_decide", 32'(dbg_state2), 32'(S_DECIDE));
    check("sat_win_err_cnt", 32'(win_err_cnt2), 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
